ntt_core_gf64_in_arb: RTL and testbench
=======================================

NTT_CORE_GF64_IN_ARB -- requirements
Module: ntt_core_gf64_in_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, giving the number of decomposition sources sharing one NTT head; legal range 2..4.
REQ-002 SHALL have parameter PSI, default PSI (pep_common_param_pkg), giving the PSI data lanes.
REQ-003 SHALL have parameter R, default R, giving the radix lanes per PSI.
REQ-004 SHALL have parameter PBS_B_W, default PBS_B_W, giving the decomposed-coefficient width; data is PBS_B_W+1 bits in 2s complement.
REQ-005 SHALL have parameter BPBS_ID_W, default BPBS_ID_W, giving the pbs_id width.
REQ-006 SHALL have parameter BEAT_NB, default 16, giving the data beats per batch, counted by the beats carrying sob..eob.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port s_rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-009 Port src_req, input, NREQ bits: source i has a batch ready to send.
REQ-010 Port src_gnt, output, NREQ bits: one-hot grant; the granted source drives data from the next cycle.
REQ-011 Port src_data, input, NREQ x PSI x R x (PBS_B_W+1): coefficient data per source.
REQ-012 Port src_vld, input, NREQ x PSI x R: per-coefficient valid.
REQ-013 Ports src_sob, src_eob, src_sol, src_eol, src_sog, src_eog, input, NREQ bits each: batch, level and group framing.
REQ-014 Port src_pbs_id, input, NREQ x BPBS_ID_W: pbs_id per source.
REQ-015 Ports out_data, out_vld, out_sob, out_eob, out_sol, out_eol, out_sog, out_eog and out_pbs_id, output, with widths matching a single source: the stream toward the NTT head.
REQ-016 Port error, output, 2 bits: [0] is a sticky protocol violation; [1] is a sticky beat-count mismatch.

Function
REQ-017 The FSM SHALL have states IDLE and BUSY, and SHALL reset to IDLE.
REQ-018 In IDLE with src_req nonzero, the FSM SHALL pick the first requesting index at or after rr_ptr (modulo NREQ), assert src_gnt for that index, and enter BUSY on the next edge.
REQ-019 src_gnt SHALL be registered and held constant throughout BUSY.
REQ-020 A beat SHALL be defined as a cycle where the granted source's src_vld is nonzero.
REQ-021 The beat counter SHALL count beats in BUSY; BUSY ends on the beat with src_eob set.
REQ-022 On the eob beat, the FSM SHALL return to IDLE, set rr_ptr to (granted index+1) mod NREQ, and deassert src_gnt on the next edge.
REQ-023 The arbiter SHALL allow at least one idle cycle between batches, so the maximum throughput is one batch per BEAT_NB+1 cycles after the first grant.
REQ-024 The output stage SHALL register the granted source's data, vld, framing and pbs_id with 1-cycle latency.
REQ-025 When no source is granted, or the granted vld is zero, out_vld SHALL be 0 and the framing outputs SHALL be 0; out_data and out_pbs_id are don't-care but must hold their previous value.
REQ-026 There SHALL be no backpressure: the downstream is always ready, and data is never stalled or dropped.
REQ-027 error[0] SHALL set on any of: nonzero src_vld from an ungranted source; src_sob on a non-first beat; a vld beat in IDLE.
REQ-028 error[1] SHALL set when eob arrives with a beat count other than BEAT_NB, or when the count reaches BEAT_NB without eob.
REQ-029 If the count reaches BEAT_NB without eob, the FSM SHALL force a return to IDLE to avoid a deadlock.
REQ-030 The error bits SHALL clear only on reset.
REQ-031 If src_req drops while BUSY, the arbiter SHALL ignore it; the batch completes on eob.
REQ-032 If all NREQ sources request simultaneously, round robin SHALL guarantee service within NREQ batches.

Reset
REQ-033 While s_rst=1 at an edge, the block SHALL set: state IDLE, rr_ptr 0, src_gnt 0, beat counter 0, out_vld 0, all out framing 0, out_data 0, out_pbs_id 0, error 0.
REQ-034 A reset asserted mid-batch SHALL abort the batch with no further output beats.
REQ-035 After reset, the first grant SHALL go to the lowest requesting index.

Verification
REQ-036 Bench SHALL cover: NREQ=2; src_req=2'b11 after reset -> gnt 01; 16 beats out at 1-cycle latency; then gnt 10; out_pbs_id follows each source.
REQ-037 Bench SHALL cover: only source 1 requests continuously -> back-to-back grants to 1, each batch 17 cycles apart, error=0.
REQ-038 Bench SHALL cover: source 0 is granted and source 1 drives vld=1 -> error[0]=1 next cycle and stays 1; the output stream is unaffected.
REQ-039 Bench SHALL cover: eob on beat 10 -> error[1]=1 and a return to IDLE; eob absent at beat 16 -> error[1]=1 and a forced IDLE.
REQ-040 Bench SHALL cover: s_rst pulsed at beat 5 -> next cycle out_vld=0, gnt=0, state IDLE; the next grant goes to source 0.
REQ-041 Bench SHALL cover: NREQ=4 with random requests -> no source waits more than 4 batches; out_data is bit-exact to the granted source, delayed by 1 cycle.

Source files
------------

// File: rtl/ntt_core_gf64_in_arb.sv
// Round-robin input arbiter that lets NREQ decomposition sources share one NTT head.
// A grant covers one whole batch; outputs are the granted stream delayed by one register.
module ntt_core_gf64_in_arb #(
    parameter int NREQ      = 2,
    parameter int PSI       = 2,
    parameter int R         = 2,
    parameter int PBS_B_W   = 4,
    parameter int BPBS_ID_W = 4,
    parameter int BEAT_NB   = 16
) (
    input  logic                                       clk,
    input  logic                                       s_rst,
    input  logic [NREQ-1:0]                            src_req,
    output logic [NREQ-1:0]                            src_gnt,
    input  logic [NREQ-1:0][PSI*R-1:0][PBS_B_W:0]      src_data,
    input  logic [NREQ-1:0][PSI*R-1:0]                 src_vld,
    input  logic [NREQ-1:0]                            src_sob,
    input  logic [NREQ-1:0]                            src_eob,
    input  logic [NREQ-1:0]                            src_sol,
    input  logic [NREQ-1:0]                            src_eol,
    input  logic [NREQ-1:0]                            src_sog,
    input  logic [NREQ-1:0]                            src_eog,
    input  logic [NREQ-1:0][BPBS_ID_W-1:0]             src_pbs_id,
    output logic [PSI*R-1:0][PBS_B_W:0]                out_data,
    output logic [PSI*R-1:0]                           out_vld,
    output logic                                       out_sob,
    output logic                                       out_eob,
    output logic                                       out_sol,
    output logic                                       out_eol,
    output logic                                       out_sog,
    output logic                                       out_eog,
    output logic [BPBS_ID_W-1:0]                       out_pbs_id,
    output logic [1:0]                                 error
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(BEAT_NB + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             sel_hit;
    logic [CNT_W-1:0] beat_cnt;

    logic [PSI*R-1:0] g_vld;
    logic             g_eob;
    logic             beat;
    logic             last_beat;
    logic             done;
    logic             len_err;
    logic             sob_err;
    logic             proto_err;
    logic [NREQ-1:0]  stray_vld;

    // Scan offsets from the highest down so the smallest offset from rr_ptr wins.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin : rr_select
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        sel_idx  = rr_ptr;
        sel_hit  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDX_W'(cand);
            if (src_req[cand_idx]) begin
                sel_idx = cand_idx;
                sel_hit = 1'b1;
            end
        end
    end

    assign g_vld     = src_vld[gnt_idx];
    assign g_eob     = src_eob[gnt_idx];
    assign beat      = (state == BUSY) && (|g_vld);
    assign last_beat = (beat_cnt == CNT_W'(BEAT_NB - 1));
    // A batch ends on eob or, to avoid a deadlock, on the BEAT_NB-th beat regardless.
    assign done      = beat && (g_eob || last_beat);
    assign len_err   = beat && (g_eob != last_beat);
    assign sob_err   = beat && src_sob[gnt_idx] && (beat_cnt != '0);
    assign next_ptr  = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    for (genvar i = 0; i < NREQ; i++) begin : g_stray
        assign stray_vld[i] = (|src_vld[i]) && !((state == BUSY) && (gnt_idx == IDX_W'(i)));
    end

    assign proto_err = (|stray_vld) || sob_err;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            src_gnt  <= '0;
            beat_cnt <= '0;
            error    <= '0;
        end else begin
            error <= error | {len_err, proto_err};
            case (state)
                IDLE: begin
                    if (sel_hit) begin
                        state    <= BUSY;
                        gnt_idx  <= sel_idx;
                        src_gnt  <= NREQ'(1) << sel_idx;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state    <= IDLE;
                        src_gnt  <= '0;
                        beat_cnt <= '0;
                        rr_ptr   <= next_ptr;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the data and pbs_id holding registers are reset too, so the stream starts from known zeros.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            out_data   <= '0;
            out_vld    <= '0;
            out_sob    <= 1'b0;
            out_eob    <= 1'b0;
            out_sol    <= 1'b0;
            out_eol    <= 1'b0;
            out_sog    <= 1'b0;
            out_eog    <= 1'b0;
            out_pbs_id <= '0;
        end else begin
            out_vld <= beat ? g_vld : '0;
            out_sob <= beat && src_sob[gnt_idx];
            out_eob <= beat && g_eob;
            out_sol <= beat && src_sol[gnt_idx];
            out_eol <= beat && src_eol[gnt_idx];
            out_sog <= beat && src_sog[gnt_idx];
            out_eog <= beat && src_eog[gnt_idx];
            if (beat) begin
                out_data   <= src_data[gnt_idx];
                out_pbs_id <= src_pbs_id[gnt_idx];
            end
        end
    end

endmodule

// File: tb/tb_ntt_core_gf64_in_arb.sv
// Directed bench for ntt_core_gf64_in_arb: a 2-source instance for the framing/error
// scenarios and a 4-source instance checked against a small round-robin model.
`timescale 1ns/1ps
module tb_ntt_core_gf64_in_arb;

    localparam int PSI       = 2;
    localparam int R         = 2;
    localparam int PBS_B_W   = 4;
    localparam int BPBS_ID_W = 4;
    localparam int LANES     = PSI * R;
    localparam int DW        = LANES * (PBS_B_W + 1);
    localparam int NB2       = 16;
    localparam int NB4       = 4;

    logic clk = 1'b0;
    logic s_rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 2-source instance
    logic [1:0]                        req2, gnt2;
    logic [1:0][LANES-1:0][PBS_B_W:0]  sdata2;
    logic [1:0][LANES-1:0]             svld2;
    logic [1:0]                        ssob2, seob2, ssol2, seol2, ssog2, seog2;
    logic [1:0][BPBS_ID_W-1:0]         spid2;
    logic [LANES-1:0][PBS_B_W:0]       odata2;
    logic [LANES-1:0]                  ovld2;
    logic                              osob2, oeob2, osol2, oeol2, osog2, oeog2;
    logic [BPBS_ID_W-1:0]              opid2;
    logic [1:0]                        err2;

    // 4-source instance
    logic [3:0]                        req4, gnt4;
    logic [3:0][LANES-1:0][PBS_B_W:0]  sdata4;
    logic [3:0][LANES-1:0]             svld4;
    logic [3:0]                        ssob4, seob4, szero4;
    logic [3:0][BPBS_ID_W-1:0]         spid4;
    logic [LANES-1:0][PBS_B_W:0]       odata4;
    logic [LANES-1:0]                  ovld4;
    logic                              osob4, oeob4, osol4, oeol4, osog4, oeog4;
    logic [BPBS_ID_W-1:0]              opid4;
    logic [1:0]                        err4;

    ntt_core_gf64_in_arb #(
        .NREQ(2), .PSI(PSI), .R(R), .PBS_B_W(PBS_B_W), .BPBS_ID_W(BPBS_ID_W), .BEAT_NB(NB2)
    ) dut2 (
        .clk(clk), .s_rst(s_rst), .src_req(req2), .src_gnt(gnt2),
        .src_data(sdata2), .src_vld(svld2),
        .src_sob(ssob2), .src_eob(seob2), .src_sol(ssol2), .src_eol(seol2),
        .src_sog(ssog2), .src_eog(seog2), .src_pbs_id(spid2),
        .out_data(odata2), .out_vld(ovld2),
        .out_sob(osob2), .out_eob(oeob2), .out_sol(osol2), .out_eol(oeol2),
        .out_sog(osog2), .out_eog(oeog2), .out_pbs_id(opid2), .error(err2)
    );

    ntt_core_gf64_in_arb #(
        .NREQ(4), .PSI(PSI), .R(R), .PBS_B_W(PBS_B_W), .BPBS_ID_W(BPBS_ID_W), .BEAT_NB(NB4)
    ) dut4 (
        .clk(clk), .s_rst(s_rst), .src_req(req4), .src_gnt(gnt4),
        .src_data(sdata4), .src_vld(svld4),
        .src_sob(ssob4), .src_eob(seob4), .src_sol(szero4), .src_eol(szero4),
        .src_sog(szero4), .src_eog(szero4), .src_pbs_id(spid4),
        .out_data(odata4), .out_vld(ovld4),
        .out_sob(osob4), .out_eob(oeob4), .out_sol(osol4), .out_eol(oeol4),
        .out_sog(osog4), .out_eog(oeog4), .out_pbs_id(opid4), .error(err4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int s, input int b);
        return DW'((s + 1) * 32'h0009_E377 + b * 32'h0001_3579);
    endfunction

    function automatic logic [BPBS_ID_W-1:0] pid(input int s);
        return BPBS_ID_W'(5 + 3 * s);
    endfunction

    // {sob, eob, sol, eol, sog, eog}: distinct patterns so swapped framing bits show up
    function automatic logic [5:0] frm(input int b, input int eob_b);
        return {b == 1, b == eob_b, b % 4 == 1, b % 4 == 0, b % 8 == 1, b % 8 == 0};
    endfunction

    task automatic clear2();
        svld2 = '0; ssob2 = '0; seob2 = '0; ssol2 = '0; seol2 = '0; ssog2 = '0; seog2 = '0;
    endtask

    task automatic clear4();
        svld4 = '0; ssob4 = '0; seob4 = '0;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        req2  = '0;
        req4  = '0;
        clear2();
        clear4();
        repeat (2) @(posedge clk);
        #1;
        s_rst = 1'b0;
    endtask

    task automatic drive_beat2(input int s, input int b, input int eob_b);
        clear2();
        svld2[1'(s)]  = '1;
        sdata2[1'(s)] = pat(s, b);
        spid2[1'(s)]  = pid(s);
        {ssob2[1'(s)], seob2[1'(s)], ssol2[1'(s)], seol2[1'(s)], ssog2[1'(s)], seog2[1'(s)]} = frm(b, eob_b);
    endtask

    task automatic check_beat2(input int s, input int b, input int eob_b);
        check("out_vld", 64'(ovld2), 64'({LANES{1'b1}}));
        check("out_data", 64'(odata2), 64'(pat(s, b)));
        check("out_pbs_id", 64'(opid2), 64'(pid(s)));
        check("out_framing", 64'({osob2, oeob2, osol2, oeol2, osog2, oeog2}), 64'(frm(b, eob_b)));
    endtask

    // Source s sends n beats starting now; optional intruding vld from the other source at beat intr.
    task automatic run_batch2(input int s, input int n, input int eob_b, input int intr, input int err1_end);
        for (int b = 1; b <= n; b++) begin
            drive_beat2(s, b, eob_b);
            if (intr != 0 && b == intr) begin
                svld2[1'(1 - s)]  = '1;
                sdata2[1'(1 - s)] = '1;
            end
            @(posedge clk);
            #1;
            check_beat2(s, b, eob_b);
            check("gnt_in_batch", 64'(gnt2), (b == n) ? 64'(0) : 64'(2'b01 << s));
            check("error0", 64'(err2[0]), 64'(intr != 0 && b >= intr));
            check("error1", 64'(err2[1]), 64'(b == n && err1_end != 0));
        end
        clear2();
    endtask

    task automatic wait_gnt2(input logic [1:0] exp, input string tag);
        int n = 0;
        while (gnt2 == '0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(gnt2), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_start;
        logic [3:0] pend;
        logic [3:0] onehot;
        int rr_m, g_exp, gi, idx;
        int waits [4];
        logic [DW-1:0] dv;
        logic [LANES-1:0] vv;
        logic [BPBS_ID_W-1:0] pv;

        szero4 = '0;
        sdata2 = '0; spid2 = '0; sdata4 = '0; spid4 = '0;
        do_reset();

        // reset state
        check("rst_gnt", 64'(gnt2), 64'(0));
        check("rst_out_vld", 64'(ovld2), 64'(0));
        check("rst_out_data", 64'(odata2), 64'(0));
        check("rst_out_pbs_id", 64'(opid2), 64'(0));
        check("rst_framing", 64'({osob2, oeob2, osol2, oeol2, osog2, oeog2}), 64'(0));
        check("rst_error", 64'(err2), 64'(0));
        check("rst_gnt4", 64'(gnt4), 64'(0));

        // both request: source 0 first, then source 1 after one idle cycle
        req2 = 2'b11;
        wait_gnt2(2'b01, "first_gnt");
        run_batch2(0, NB2, NB2, 0, 0);
        @(posedge clk);
        #1;
        check("idle_out_vld", 64'(ovld2), 64'(0));
        check("second_gnt", 64'(gnt2), 64'(2'b10));
        run_batch2(1, NB2, NB2, 0, 0);
        req2 = 2'b00;
        @(posedge clk);
        #1;
        check("no_req_gnt", 64'(gnt2), 64'(0));
        check("hold_out_data", 64'(odata2), 64'(pat(1, NB2)));
        check("hold_out_pbs_id", 64'(opid2), 64'(pid(1)));

        // only source 1 requests: back-to-back grants BEAT_NB+1 cycles apart
        req2 = 2'b10;
        t_start = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("b2b_gnt", 64'(gnt2), 64'(2'b10));
            if (k > 0) check("b2b_period", 64'(cyc - t_start), 64'(NB2 + 1));
            t_start = cyc;
            run_batch2(1, NB2, NB2, 0, 0);
        end
        req2 = 2'b00;
        check("b2b_error", 64'(err2), 64'(0));

        // ungranted source drives vld; request dropped mid-batch is ignored
        do_reset();
        req2 = 2'b01;
        wait_gnt2(2'b01, "stray_gnt");
        req2 = 2'b00;
        run_batch2(0, NB2, NB2, 3, 0);
        repeat (2) @(posedge clk);
        #1;
        check("stray_sticky", 64'(err2), 64'(2'b01));

        // eob early at beat 10
        do_reset();
        req2 = 2'b01;
        wait_gnt2(2'b01, "short_gnt");
        req2 = 2'b00;
        run_batch2(0, 10, 10, 0, 1);
        @(posedge clk);
        #1;
        check("short_idle_gnt", 64'(gnt2), 64'(0));
        check("short_sticky", 64'(err2), 64'(2'b10));

        // eob missing: forced back to IDLE after BEAT_NB beats
        do_reset();
        req2 = 2'b01;
        wait_gnt2(2'b01, "long_gnt");
        req2 = 2'b00;
        run_batch2(0, NB2, 0, 0, 1);
        @(posedge clk);
        #1;
        check("long_idle_gnt", 64'(gnt2), 64'(0));
        check("long_sticky", 64'(err2), 64'(2'b10));

        // reset pulsed while beat 5 is presented
        do_reset();
        req2 = 2'b11;
        wait_gnt2(2'b01, "abort_gnt");
        for (int b = 1; b <= 4; b++) begin
            drive_beat2(0, b, NB2);
            @(posedge clk);
            #1;
            check_beat2(0, b, NB2);
        end
        drive_beat2(0, 5, NB2);
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        clear2();
        check("abort_out_vld", 64'(ovld2), 64'(0));
        check("abort_gnt", 64'(gnt2), 64'(0));
        check("abort_out_data", 64'(odata2), 64'(0));
        check("abort_framing", 64'({osob2, oeob2, osol2, oeol2, osog2, oeog2}), 64'(0));
        @(posedge clk);
        #1;
        check("abort_regrant", 64'(gnt2), 64'(2'b01));
        req2 = 2'b00;
        run_batch2(0, NB2, NB2, 0, 0);

        // 4 sources, random request arrivals, checked against a round-robin model
        do_reset();
        rr_m = 0;
        pend = '0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        for (int n = 0; n < 24; n++) begin
            pend = pend | 4'($urandom);
            if (pend == '0) pend = 4'b0001 << $urandom_range(3, 0);
            g_exp = rr_m;
            for (int k = 3; k >= 0; k--) begin
                idx = (rr_m + k) % 4;
                if (pend[idx[1:0]]) g_exp = idx;
            end
            req4 = pend;
            @(posedge clk);
            #1;
            check("rr4_gnt", 64'(gnt4), 64'(4'b0001 << g_exp));
            gi = g_exp;
            for (int i = 0; i < 4; i++) if (gnt4 == (4'b0001 << i)) gi = i;
            check("rr4_wait_le3", 64'(waits[gi] <= 3), 64'(1));
            for (int i = 0; i < 4; i++) begin
                onehot = 4'b0001 << i;
                if (i != gi && (pend & onehot) != '0) waits[i]++;
            end
            waits[gi] = 0;
            pend = pend & ~(4'b0001 << g_exp);
            req4 = pend;
            for (int b = 1; b <= NB4; b++) begin
                for (int i = 0; i < 4; i++) begin
                    sdata4[2'(i)] = DW'($urandom);
                    spid4[2'(i)]  = BPBS_ID_W'($urandom);
                end
                vv = LANES'($urandom_range((1 << LANES) - 1, 1));
                dv = sdata4[2'(g_exp)];
                pv = spid4[2'(g_exp)];
                clear4();
                svld4[2'(g_exp)] = vv;
                ssob4[2'(g_exp)] = (b == 1);
                seob4[2'(g_exp)] = (b == NB4);
                @(posedge clk);
                #1;
                check("rr4_out_data", 64'(odata4), 64'(dv));
                check("rr4_out_vld", 64'(ovld4), 64'(vv));
                check("rr4_out_pbs_id", 64'(opid4), 64'(pv));
                check("rr4_out_sob_eob", 64'({osob4, oeob4}), 64'({b == 1, b == NB4}));
            end
            clear4();
            check("rr4_gnt_after_eob", 64'(gnt4), 64'(0));
            rr_m = (g_exp + 1) % 4;
        end
        req4 = '0;
        check("rr4_error", 64'(err4), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
